pc_fetch_sequencer: RTL
=======================

# pc_fetch_sequencer

Owns the program counter and sequences instruction fetch for the RV32I core. Issues one instruction-memory request at a time on a valid/ready handshake and delivers each returned instruction with its PC. Computes PC+4 through a dedicated incrementer and accepts branch/jump redirects from execute. Sits between the core's control/execute stage and instruction memory, replacing a free-running PC register.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded by reset; bits [1:0] must be 0
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned redirect; bits [1:0] must be 0
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  suppresses issue of a new request
- redirect_valid  in  1  one-cycle redirect pulse from execute
- redirect_target  in  32  new PC for redirect
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  request address (current PC)
- imem_rsp_valid  in  1  response returned (instruction data bypasses this block)
- instr_valid  out  1  returned instruction is live
- instr_pc  out  32  PC of the live instruction
- trap_valid  out  1  misaligned-redirect trap pulse
- trap_tval  out  32  offending redirect target

## Operation
- States: IDLE, REQ, WAIT, DRAIN. Reset: state IDLE, pc = RESET_VECTOR, trap_tval = 0, trap_valid = 0.
- IDLE: no request; next state REQ unconditionally.
- REQ: imem_req_valid = !stall; imem_addr = pc.
  - Accepted (valid & ready) and no redirect -> WAIT, pc unchanged.
  - Redirect, not accepted -> pc = target, stay REQ.
  - Redirect and accepted in same cycle -> pc = target, go DRAIN (in-flight response discarded).
- WAIT: imem_req_valid = 0.
  - rsp_valid and no redirect -> instr_valid = 1, instr_pc = pc; pc = pc+4; -> REQ.
  - Redirect with rsp_valid -> response discarded (instr_valid = 0), pc = target, -> REQ.
  - Redirect without rsp_valid -> pc = target, -> DRAIN.
- DRAIN: rsp_valid -> discard, -> REQ. Further redirect in DRAIN: pc = latest target, stay DRAIN until response.
- instr_valid and instr_pc are combinational from state/pc/rsp_valid; zero outside WAIT.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000, no flag.
- Redirect always wins over increment; stall never blocks a redirect or a response.
- Responses outside WAIT/DRAIN are protocol errors; ignored.

## Timing
- rst deasserted at edge N -> IDLE in cycle N, first imem_req_valid in cycle N+1.
- Min fetch period 2 cycles (REQ, WAIT with same-cycle-next response); 1-cycle memory yields 1 instr / 2 cycles.
- Redirect takes effect on next edge: next imem_addr = target (or TRAP_VECTOR).
- trap_valid is a registered 1-cycle pulse, cycle after the redirect.
- rst asserted in any state: next edge forces IDLE and reset values; pending response ignored.

## Configuration
- PC_MISALIGN_TRAP_EN defined: redirect_target[1:0] != 0 -> pc = TRAP_VECTOR, trap_valid pulse, trap_tval = target; state transitions as for normal redirect.
- Undefined: redirect_target[1:0] forced to 0 before load; trap_valid and trap_tval tied to 0.

## Structure
- Package pc_seq_pkg: state encoding (2-bit IDLE/REQ/WAIT/DRAIN), XLEN = 32, INSTR_BYTES = 4.
- Sub-module pc_increment: combinational 32-bit pc + INSTR_BYTES, instantiated once.

## Test plan
- Reset then ready=1, rsp one cycle after accept -> addrs 0x0, 0x4, 0x8 on cycles 1, 3, 5; instr_pc matches.
- PC = 0xFFFF_FFFC, response -> next imem_addr 0x0000_0000.
- Redirect to 0x200 in WAIT before response; response 2 cycles later -> no instr_valid, next imem_addr 0x200.
- Redirect to 0x80 in same cycle as accept -> DRAIN, response discarded, next imem_addr 0x80.
- stall held 3 cycles in REQ -> imem_req_valid low 3 cycles, pc unchanged; redirect during stall still updates pc.
- With PC_MISALIGN_TRAP_EN, redirect to 0x102 -> trap_valid pulse, trap_tval 0x102, next addr 0x100; without macro -> next addr 0x100, no trap.

Source files
------------

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared types and constants for the PC fetch sequencer.
// Revision : 1.0
// ============================================================================
package pc_seq_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_increment.sv
`default_nettype none
// ============================================================================
// Module   : pc_increment
// Brief    : Combinational next-sequential-PC adder (wraps modulo 2^XLEN).
// Revision : 1.0
// ============================================================================
module pc_increment
    import pc_seq_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_o
);

    assign pc_o = pc_i + XLEN'(INSTR_BYTES);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Brief    : Owns the PC and sequences one-at-a-time instruction fetches.
//            Optional macro PC_MISALIGN_TRAP_EN enables misaligned-redirect traps.
// Revision : 1.0
// ============================================================================
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_pc,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_tval
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_accept;

    pc_increment u_pc_increment (
        .pc_i (pc_q),
        .pc_o (w_pc_plus4)
    );

`ifdef PC_MISALIGN_TRAP_EN
    logic            w_misaligned;
    logic            trap_valid_q;
    logic [XLEN-1:0] trap_tval_q;

    assign w_misaligned  = (redirect_target[1:0] != 2'b00);
    assign w_redirect_pc = w_misaligned ? TRAP_VECTOR : redirect_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_valid_q <= 1'b0;
            trap_tval_q  <= '0;
        end else begin
            trap_valid_q <= redirect_valid && w_misaligned;
            if (redirect_valid && w_misaligned) begin
                trap_tval_q <= redirect_target;
            end
        end
    end

    assign trap_valid = trap_valid_q;
    assign trap_tval  = trap_tval_q;
`else
    // Low bits are dropped so a misaligned target silently rounds down.
    assign w_redirect_pc = redirect_target & ~32'h0000_0003;
    assign trap_valid    = 1'b0;
    assign trap_tval     = '0;

    logic w_unused_trap_vector;
    assign w_unused_trap_vector = ^TRAP_VECTOR;
`endif

    assign imem_req_valid = (state_q == ST_REQ) && !stall;
    assign imem_addr      = pc_q;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // A response coinciding with reset or a redirect is never delivered.
    assign instr_valid = (state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid && !rst;
    assign instr_pc    = (state_q == ST_WAIT) ? pc_q : '0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect_valid) begin
                    pc_d = w_redirect_pc;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d    = w_redirect_pc;
                    state_d = w_accept ? ST_DRAIN : ST_REQ;
                end else if (w_accept) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = w_redirect_pc;
                    state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    pc_d    = w_pc_plus4;
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = w_redirect_pc;
                end
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule
`default_nettype wire
